// File: rtl/btn_evt_pkg.sv
// Shared types for the button event controller: the event codes presented
// to the consumer, the press-classification FSM states, and a small helper.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EVT_NONE   = 2'b00,
    EVT_SINGLE = 2'b01,
    EVT_DOUBLE = 2'b10,
    EVT_LONG   = 2'b11
  } evt_code_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    HOLD   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_e;

  // Larger of two integers, used to size the shared cycle counter.
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/button_event_ctrl.sv
// Button event controller: classifies a debounced button level into
// SINGLE, DOUBLE and LONG press events. Events are offered on a
// single-entry valid/ready register; an event that arrives while the held
// one is still waiting is dropped and flagged on a sticky overrun bit.
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int LONG_PRESS_CYCLES = 12_500_000,
  parameter int DCLICK_WINDOW     = 7_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_level,
  output logic       press_pulse,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_overrun
);

  // Counter only ever reaches (parameter - 1), so this width never wraps.
  localparam int CNT_MAX = max_int(LONG_PRESS_CYCLES, DCLICK_WINDOW);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DCLICK_WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             prev_level_r;
  logic             rise_s;
  logic             fall_s;
  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             new_evt_s;
  evt_code_e        new_code_s;
  logic             press_pulse_r;
  logic             evt_valid_r;
  evt_code_e        evt_code_r;
  logic             evt_overrun_r;

  assign rise_s = btn_level & ~prev_level_r;
  assign fall_s = ~btn_level & prev_level_r;

  assign press_pulse = press_pulse_r;
  assign evt_valid   = evt_valid_r;
  assign evt_code    = evt_code_r;
  assign evt_overrun = evt_overrun_r;

  // Edge detector history and the one-cycle press strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_level_r  <= 1'b0;
      press_pulse_r <= 1'b0;
    end else begin
      prev_level_r  <= btn_level;
      press_pulse_r <= rise_s;
    end
  end

  // FSM state and cycle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Press classification: next state, next count and the event decided this cycle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    new_evt_s   = 1'b0;
    new_code_s  = EVT_NONE;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_nxt_s = PRESS1;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRESS1: begin
        if (fall_s) begin
          state_nxt_s = GAP;
          cnt_nxt_s   = '0;
        end else if ((cnt_r == LONG_LAST) && btn_level) begin
          state_nxt_s = HOLD;
          cnt_nxt_s   = '0;
          new_evt_s   = 1'b1;
          new_code_s  = EVT_LONG;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      HOLD: begin
        // Long press already reported; the release is silent.
        if (fall_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      GAP: begin
        // A second press wins over the window closing in the same cycle.
        if (rise_s) begin
          state_nxt_s = PRESS2;
          cnt_nxt_s   = '0;
        end else if (cnt_r == GAP_LAST) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
          new_evt_s   = 1'b1;
          new_code_s  = EVT_SINGLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      PRESS2: begin
        if (fall_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
          new_evt_s   = 1'b1;
          new_code_s  = EVT_DOUBLE;
        end else begin
          state_nxt_s = PRESS2;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Single-entry event register with drop-on-full and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid_r   <= 1'b0;
      evt_code_r    <= EVT_NONE;
      evt_overrun_r <= 1'b0;
    end else if (evt_valid_r && !evt_ready) begin
      if (new_evt_s) begin
        evt_overrun_r <= 1'b1;
      end else begin
        evt_overrun_r <= evt_overrun_r;
      end
    end else if (new_evt_s) begin
      evt_valid_r <= 1'b1;
      evt_code_r  <= new_code_s;
    end else begin
      evt_valid_r <= 1'b0;
      evt_code_r  <= EVT_NONE;
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl. Button activity is described as
// alternating high/low durations; event times are derived from those
// durations with plain arithmetic, and a transaction-level slot model turns
// them into expected handshakes that a separate monitor checks.
module tb_button_event_ctrl;
  import btn_evt_pkg::*;

  localparam int L = 8;
  localparam int D = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_level = 1'b0;
  logic       evt_ready = 1'b0;
  logic       press_pulse;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_overrun;

  button_event_ctrl #(.LONG_PRESS_CYCLES(L), .DCLICK_WINDOW(D)) dut (
    .clk(clk), .rst(rst), .btn_level(btn_level), .press_pulse(press_pulse),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .evt_overrun(evt_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [1:0] code;
  } acc_t;

  acc_t       exp_q[$];
  int         pulse_q[$];
  logic [1:0] ev_at[int];
  int         seg_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         m_v = 1'b0;
  logic [1:0] m_c = 2'b00;
  bit         m_ovr = 1'b0;
  bit         chk_reset_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every handshake and every press strobe is matched against the queues.
  always @(negedge clk) begin
    acc_t a;
    int   p;
    if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_accept", 32'(exp_q.size()), 32'd1);
      end else begin
        a = exp_q.pop_front();
        check("accept_cycle", 32'(cyc), 32'(a.t));
        check("accept_code", 32'(evt_code), 32'(a.code));
      end
    end
    if (press_pulse === 1'b1) begin
      if (pulse_q.size() == 0) begin
        check("unexpected_pulse", 32'(pulse_q.size()), 32'd1);
      end else begin
        p = pulse_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(p));
      end
    end
  end

  // Event schedule from press/release durations (decision cycle -> code).
  task automatic plan(input int start);
    int t, i, h, g, f, h2, g2;
    t = start;
    i = 0;
    while (i + 1 < seg_q.size()) begin
      h = seg_q[i];
      g = seg_q[i+1];
      pulse_q.push_back(t + 1);
      if (h > L) begin
        ev_at[t + L] = EVT_LONG;
        t = t + h + g;
        i = i + 2;
      end else if (g > D) begin
        ev_at[t + h + D] = EVT_SINGLE;
        t = t + h + g;
        i = i + 2;
      end else begin
        f  = t + h;
        h2 = seg_q[i+2];
        g2 = seg_q[i+3];
        pulse_q.push_back(f + g + 1);
        ev_at[f + g + h2] = EVT_DOUBLE;
        t = f + g + h2 + g2;
        i = i + 4;
      end
    end
  endtask

  // One clock cycle of stimulus plus the transaction-level output-slot model.
  task automatic step(input logic lvl, input logic rdy, input logic r);
    int   t;
    logic acc;
    @(posedge clk);
    #1;
    btn_level = lvl;
    evt_ready = rdy;
    rst = r;
    t = cyc;
    if (r) begin
      m_v = 1'b0;
      m_c = 2'b00;
      m_ovr = 1'b0;
      ev_at.delete();
      while (pulse_q.size() > 0 && pulse_q[$] > t) void'(pulse_q.pop_back());
    end else begin
      acc = m_v && rdy;
      if (acc) exp_q.push_back('{t, m_c});
      if (ev_at.exists(t)) begin
        if (m_v && !rdy) m_ovr = 1'b1;
        else begin
          m_v = 1'b1;
          m_c = ev_at[t];
        end
      end else if (acc) begin
        m_v = 1'b0;
      end
    end
    if (chk_reset_pending) begin
      #1;
      check("rst_press_pulse", 32'(press_pulse), 32'd0);
      check("rst_evt_valid", 32'(evt_valid), 32'd0);
      check("rst_evt_code", 32'(evt_code), 32'd0);
      check("rst_evt_overrun", 32'(evt_overrun), 32'd0);
      chk_reset_pending = 1'b0;
    end
  endtask

  // Drive seg_q with a ready policy: 0 always, 1 random, 2 never, 3 only on decision cycles.
  task automatic run_episode(input int mode);
    int   start, off;
    logic rdy;
    start = cyc + 1;
    plan(start);
    off = 0;
    for (int i = 0; i < seg_q.size(); i++) begin
      for (int k = 0; k < seg_q[i]; k++) begin
        case (mode)
          0: rdy = 1'b1;
          1: rdy = ($urandom_range(0, 3) != 0);
          2: rdy = 1'b0;
          default: rdy = ev_at.exists(start + off);
        endcase
        step((i % 2) == 0, rdy, 1'b0);
        off++;
      end
    end
    repeat (4) step(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check("overrun", 32'(evt_overrun), 32'(m_ovr));
    check("valid_drained", 32'(evt_valid), 32'(m_v));
    check("accepts_outstanding", 32'(exp_q.size()), 32'd0);
    check("pulses_outstanding", 32'(pulse_q.size()), 32'd0);
  endtask

  initial begin
    int r0, k, g;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk_reset_pending = 1'b1;

    seg_q = '{3, 8};          run_episode(0);   // single press
    seg_q = '{3, 2, 2, 8};    run_episode(0);   // double press
    seg_q = '{20, 8};         run_episode(0);   // long press
    seg_q = '{3, 8, 20, 8};   run_episode(2);   // back-pressure drops the LONG
    check("overrun_sticky", 32'(evt_overrun), 32'd1);

    // Reset in the middle of a first press, level still high afterwards.
    step(1'b0, 1'b1, 1'b0);
    r0 = cyc + 1;
    pulse_q.push_back(r0 + 1);
    repeat (4) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk_reset_pending = 1'b1;
    seg_q = '{3, 8};          run_episode(0);

    seg_q = '{3, 8, 12, 8};   run_episode(3);   // accept coincides with new LONG
    check("no_overrun_on_accept", 32'(evt_overrun), 32'd0);

    // Randomized press patterns around the timing boundaries.
    for (int e = 0; e < 8; e++) begin
      seg_q.delete();
      k = $urandom_range(4, 10);
      for (int j = 0; j < k; j++) begin
        seg_q.push_back($urandom_range(1, L + 3));
        g = (j == k - 1) ? (D + 1 + $urandom_range(0, 3)) : $urandom_range(1, D + 3);
        seg_q.push_back(g);
      end
      run_episode(e % 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
